snn_cim_wb_bank_ctrl: RTL and testbench
=======================================

// Module: snn_cim_wb_bank_ctrl
// PURPOSE
//  Wishbone slave front-end for NUM_CORES Neuromorphic CIM macro cores in the user project area.
//  Decodes the core index from the address and forwards each transfer over a per-core stb/ack handshake.
//  Adds broadcast writes, a per-core enable mask, a response timeout with sticky flags, and a timeout IRQ,
//  so an unresponsive macro never hangs the management SoC bus.
// PARAMETERS
//  NUM_CORES      4            number of attached CIM cores (1..8)
//  BASE_ADDR      32'h3000_0000  block base; match on wbs_adr_i[31:24]
//  CORE_AW        16           core-side byte address width (<= 20)
//  TIMEOUT_CYCLES 16'd1024     reset value of the TIMEOUT_LIMIT register
// PORTS
//  wb_clk_i    in   1             sole clock
//  wb_rst_ni   in   1             asynchronous reset, active-low
//  wbs_stb_i   in   1             Wishbone strobe
//  wbs_cyc_i   in   1             Wishbone cycle
//  wbs_we_i    in   1             Wishbone write enable
//  wbs_sel_i   in   4             byte lane selects
//  wbs_dat_i   in   32            write data
//  wbs_adr_i   in   32            byte address
//  wbs_ack_o   out  1             one-cycle acknowledge
//  wbs_dat_o   out  32            read data, valid only while wbs_ack_o = 1
//  core_stb_o  out  NUM_CORES     per-core request strobe
//  core_we_o   out  1             shared write enable
//  core_sel_o  out  4             shared byte selects
//  core_adr_o  out  CORE_AW       shared core byte address (wbs_adr_i[CORE_AW-1:0])
//  core_dat_o  out  32            shared write data
//  core_dat_i  in   32*NUM_CORES  read data; core k in bits [32k+31:32k]
//  core_ack_i  in   NUM_CORES     per-core acknowledge
//  irq_o       out  1             timeout interrupt, registered
// BEHAVIOUR
//  Reset: all outputs 0; flags=0; irq_en=0; enable mask=all ones; TIMEOUT_LIMIT=TIMEOUT_CYCLES.
//   Reset is immediate, including mid-transfer: every core_stb_o drops at once.
//  Decode (only when cyc&stb and adr[31:24] match; otherwise ignore, no ack). idx = adr[23:20]:
//   idx<NUM_CORES: forward to that core. 0xE: broadcast. 0xF: control regs. Any other idx: error response.
//  FSM states: IDLE, FWD, BCAST, RESP.
//  IDLE
//   Core idx, enabled -> latch we/sel/adr/dat, assert core_stb_o[idx] next cycle -> FWD.
//   Core idx, disabled, or error idx -> RESP with dat=32'hDEAD_C0DE.
//   0xE write -> stb on all enabled cores -> BCAST. 0xE read -> RESP, dat=0. 0xE write with mask=0 -> RESP.
//   0xF -> register access this cycle -> RESP.
//  Control regs (full-word, sel ignored):
//   0x0 FLAGS: RO [NUM_CORES-1:0] sticky timeout flags; writing 1 clears a bit.
//   0x4 CTRL: [0] irq_en; [8+NUM_CORES-1:8] enable mask.
//   0x8 TIMEOUT_LIMIT: [15:0]; 0 disables timeout.
//   Other offsets read 0; writes to them have no effect.
//  FWD
//   core_ack_i[idx] -> capture that core's read slice, drop stb -> RESP.
//   The timeout counter clears on entry and increments each cycle.
//   If the count reaches LIMIT with no ack: drop stb, set flag[idx], dat=32'hDEAD_BEEF -> RESP.
//   An ack in the same cycle as a timeout wins.
//  BCAST
//   pending = enable mask. Each ack clears its pending bit and drops its stb. pending==0 -> RESP, dat=0.
//   On timeout: set flags for every still-pending core, drop all stb -> RESP.
//  RESP: wbs_ack_o=1 for exactly one cycle -> IDLE.
//  Abort: wbs_cyc_i=0 in FWD or BCAST -> drop all stb -> IDLE. No ack, no flag.
//  core_we/sel/adr/dat_o stay stable while any core_stb_o is high.
//  Latency:
//   Control reg access: ack in the cycle after acceptance.
//   Forwarded access: core_stb_o rises the cycle after acceptance; wbs_ack_o comes 1 cycle after core_ack_i.
//  A flag set and a W1C clear in the same cycle: set wins.
//  irq_o = registered (irq_en & |flags).
// TESTING
//  Read core 2, core acks 3 cycles after stb with 32'h1234_5678 -> wbs_ack_o one cycle later, dat=32'h1234_5678.
//  Broadcast write, mask=4'b1011, cores ack on cycles 1/4/2 -> stb only on 0,1,3; one ack after the last core ack.
//  LIMIT=8, core 1 never acks -> ack after 8 stb cycles; dat=DEAD_BEEF; FLAGS=0x2; irq_o=1 if irq_en=1.
//  Write 0x2 to FLAGS -> FLAGS=0, irq_o falls next cycle. Also check same-cycle timeout vs clear: set wins.
//  Disabled core / idx 0x9 / non-matching base -> DEAD_C0DE ack / DEAD_C0DE ack / no ack.
//  Reset asserted mid-FWD -> stb drops immediately; after release CTRL reads 0x0000_0F00 with NUM_CORES=4.

Source files
------------

// File: rtl/snn_cim_wb_bank_ctrl.sv
// ---------------------------------------------------------------------------
// snn_cim_wb_bank_ctrl
//
// Wishbone slave front-end for a bank of neuromorphic CIM macro cores.
// A transfer whose address top byte matches BASE_ADDR[31:24] is decoded by
// adr[23:20]:
//   0 .. NUM_CORES-1 : forwarded to that core over its stb/ack pair
//   0xE              : broadcast write to every enabled core
//   0xF              : local control registers
//   anything else    : error response (32'hDEAD_C0DE)
// A programmable response timeout (TIMEOUT_LIMIT) keeps an unresponsive
// core from hanging the bus. A timeout sets a sticky per-core flag. irq_o
// is the registered value of (irq_en & |flags).
//
// Control registers (full word, sel ignored):
//   0x0 FLAGS         [NUM_CORES-1:0] sticky timeout flags, write 1 to clear
//   0x4 CTRL          [0] irq_en, [8+NUM_CORES-1:8] core enable mask
//   0x8 TIMEOUT_LIMIT [15:0], 0 disables the timeout
//
// Handshakes:
//   Wishbone side: a request is present while cyc & stb are high. wbs_ack_o
//   pulses for exactly one cycle to complete it. wbs_dat_o is meaningful only
//   in that cycle. Dropping cyc before the ack abandons the transfer.
//   Core side: core_stb_o[k] is held high until core_ack_i[k] is seen, a
//   timeout occurs, or the master aborts. core_we/sel/adr/dat_o are held
//   stable for that whole window. A core's ack is accepted only while its
//   own strobe is high.
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   wbs_*                    Wishbone slave interface
//   core_stb_o, core_ack_i   per-core request/acknowledge
//   core_we/sel/adr/dat_o    shared request payload to the cores
//   core_dat_i               packed read data, core k in [32k+31:32k]
//   irq_o                    timeout interrupt (registered)
//   fsm_state                controller state for debug/observation
// ---------------------------------------------------------------------------
module snn_cim_wb_bank_ctrl #(
    parameter int unsigned NUM_CORES      = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int unsigned CORE_AW        = 16,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_CORES-1:0]    core_stb_o,
    output logic                    core_we_o,
    output logic [3:0]              core_sel_o,
    output logic [CORE_AW-1:0]      core_adr_o,
    output logic [31:0]             core_dat_o,
    input  logic [32*NUM_CORES-1:0] core_dat_i,
    input  logic [NUM_CORES-1:0]    core_ack_i,
    output logic                    irq_o,
    output logic [1:0]              fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        BCAST = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_C0DE;
    localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

    state_t                 state, state_d;
    logic [NUM_CORES-1:0]   stb_q, stb_d;
    logic [NUM_CORES-1:0]   pending_q, pending_d;
    logic [NUM_CORES-1:0]   flags_q, flags_d;
    logic [NUM_CORES-1:0]   mask_q, mask_d;
    logic [NUM_CORES-1:0]   flag_set, flag_clr;
    logic                   we_q, we_d;
    logic [3:0]             sel_q, sel_d;
    logic [CORE_AW-1:0]     adr_q, adr_d;
    logic [31:0]            dat_q, dat_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            limit_q, limit_d;
    logic [31:0]            resp_q, resp_d;
    logic                   irq_en_q, irq_en_d;
    logic                   irq_q;

    logic                   req;
    logic [3:0]             idx;
    logic                   is_core;
    logic [NUM_CORES-1:0]   idx_onehot;
    logic [31:0]            reg_rdata;
    logic [31:0]            fwd_rdata;
    logic                   fwd_ack;
    logic                   timeout;
    logic [NUM_CORES-1:0]   left;

    assign req        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
    assign idx        = wbs_adr_i[23:20];
    assign is_core    = (32'(idx) < NUM_CORES);
    assign idx_onehot = is_core ? (NUM_CORES'(1) << idx) : '0;

    // In FWD exactly one strobe is high, so it doubles as the target select.
    assign fwd_ack = |(core_ack_i & stb_q);

    // The counter is 0 in the first strobe cycle, so reaching LIMIT means
    // this is the LIMIT-th cycle with the strobe up.
    assign timeout = (limit_q != 16'd0) && (cnt_q == (limit_q - 16'd1));

    // Broadcast cores still outstanding once this cycle's acks are applied.
    assign left = pending_q & ~core_ack_i;

    always_comb begin
        reg_rdata = '0;
        case (wbs_adr_i[19:0])
            20'h0: reg_rdata[NUM_CORES-1:0] = flags_q;
            20'h4: begin
                reg_rdata[0]              = irq_en_q;
                reg_rdata[8 +: NUM_CORES] = mask_q;
            end
            20'h8: reg_rdata[15:0] = limit_q;
            default: reg_rdata = '0;
        endcase
    end

    always_comb begin
        fwd_rdata = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (stb_q[k]) begin
                fwd_rdata = core_dat_i[32*k +: 32];
            end
        end
    end

    // Next-state and next-value logic.
    always_comb begin
        state_d   = state;
        stb_d     = stb_q;
        pending_d = pending_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        mask_d    = mask_q;
        irq_en_d  = irq_en_q;
        limit_d   = limit_q;
        flag_set  = '0;
        flag_clr  = '0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (is_core) begin
                        if (|(idx_onehot & mask_q)) begin
                            we_d    = wbs_we_i;
                            sel_d   = wbs_sel_i;
                            adr_d   = wbs_adr_i[CORE_AW-1:0];
                            dat_d   = wbs_dat_i;
                            stb_d   = idx_onehot;
                            cnt_d   = 16'd0;
                            state_d = FWD;
                        end else begin
                            resp_d  = ERR_DATA;
                            state_d = RESP;
                        end
                    end else if (idx == 4'hE) begin
                        if (wbs_we_i && (mask_q != '0)) begin
                            we_d      = wbs_we_i;
                            sel_d     = wbs_sel_i;
                            adr_d     = wbs_adr_i[CORE_AW-1:0];
                            dat_d     = wbs_dat_i;
                            stb_d     = mask_q;
                            pending_d = mask_q;
                            cnt_d     = 16'd0;
                            state_d   = BCAST;
                        end else begin
                            // Broadcast reads and empty-mask writes complete locally.
                            resp_d  = 32'd0;
                            state_d = RESP;
                        end
                    end else if (idx == 4'hF) begin
                        resp_d = reg_rdata;
                        if (wbs_we_i) begin
                            case (wbs_adr_i[19:0])
                                20'h0: flag_clr = wbs_dat_i[NUM_CORES-1:0];
                                20'h4: begin
                                    irq_en_d = wbs_dat_i[0];
                                    mask_d   = wbs_dat_i[8 +: NUM_CORES];
                                end
                                20'h8: limit_d = wbs_dat_i[15:0];
                                default: ;
                            endcase
                        end
                        state_d = RESP;
                    end else begin
                        resp_d  = ERR_DATA;
                        state_d = RESP;
                    end
                end
            end

            FWD: begin
                if (!wbs_cyc_i) begin
                    stb_d   = '0;
                    state_d = IDLE;
                end else if (fwd_ack) begin
                    // An ack arriving with the timeout still counts as a response.
                    resp_d  = fwd_rdata;
                    stb_d   = '0;
                    state_d = RESP;
                end else if (timeout) begin
                    flag_set = stb_q;
                    resp_d   = TMO_DATA;
                    stb_d    = '0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            BCAST: begin
                if (!wbs_cyc_i) begin
                    stb_d     = '0;
                    pending_d = '0;
                    state_d   = IDLE;
                end else if (left == '0) begin
                    resp_d    = 32'd0;
                    stb_d     = '0;
                    pending_d = '0;
                    state_d   = RESP;
                end else if (timeout) begin
                    // Cores that acked this cycle are not blamed.
                    flag_set  = left;
                    resp_d    = TMO_DATA;
                    stb_d     = '0;
                    pending_d = '0;
                    state_d   = RESP;
                end else begin
                    pending_d = left;
                    stb_d     = left;
                    cnt_d     = cnt_q + 16'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // A set in the same cycle as a write-1-to-clear takes priority.
    assign flags_d = (flags_q & ~flag_clr) | flag_set;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            stb_q     <= '0;
            pending_q <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            cnt_q     <= '0;
            resp_q    <= '0;
            flags_q   <= '0;
            mask_q    <= '1;
            irq_en_q  <= 1'b0;
            limit_q   <= TIMEOUT_CYCLES;
            irq_q     <= 1'b0;
        end else begin
            stb_q     <= stb_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            flags_q   <= flags_d;
            mask_q    <= mask_d;
            irq_en_q  <= irq_en_d;
            limit_q   <= limit_d;
            irq_q     <= irq_en_q & (|flags_q);
        end
    end

    assign wbs_ack_o  = (state == RESP);
    assign wbs_dat_o  = (state == RESP) ? resp_q : 32'd0;
    assign core_stb_o = stb_q;
    assign core_we_o  = we_q;
    assign core_sel_o = sel_q;
    assign core_adr_o = adr_q;
    assign core_dat_o = dat_q;
    assign irq_o      = irq_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_snn_cim_wb_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snn_cim_wb_bank_ctrl
//
// Bench for the CIM bank Wishbone front-end. Cores are emulated by a
// responder that acks a programmable number of cycles after its strobe
// rises (or never). Each bus transfer's outcome is predicted from the
// register/decode/timeout rules using a few model variables and per-core
// delays. It is then compared with what the DUT does on the bus.
// ---------------------------------------------------------------------------
module tb_snn_cim_wb_bank_ctrl;

    localparam int NC    = 4;
    localparam int AW    = 16;
    localparam int NEVER = -1;
    localparam logic [7:0]  BASE_HI  = 8'h30;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_C0DE;
    localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

    // ---------------- clock / reset and DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]        sel = '0;
    logic [31:0]       wdat = '0, adr = '0;
    logic              ack;
    logic [31:0]       rdat_o;
    logic [NC-1:0]     core_stb;
    logic              core_we;
    logic [3:0]        core_sel;
    logic [AW-1:0]     core_adr;
    logic [31:0]       core_dout;
    logic [32*NC-1:0]  core_din = '0;
    logic [NC-1:0]     core_ack = '0;
    logic              irq;
    logic [1:0]        fsm_state;

    always #5 clk = ~clk;

    snn_cim_wb_bank_ctrl #(
        .NUM_CORES(NC), .BASE_ADDR(32'h3000_0000), .CORE_AW(AW), .TIMEOUT_CYCLES(16'd1024)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
        .core_stb_o(core_stb), .core_we_o(core_we), .core_sel_o(core_sel),
        .core_adr_o(core_adr), .core_dat_o(core_dout),
        .core_dat_i(core_din), .core_ack_i(core_ack),
        .irq_o(irq), .fsm_state(fsm_state)
    );

    // ---------------- checking ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [NC-1:0] m_flags;
    logic [NC-1:0] m_mask;
    logic          m_irq_en;
    logic [15:0]   m_limit;
    logic [31:0]   exp_q[$];

    task automatic model_reset();
        m_flags  = '0;
        m_mask   = '1;
        m_irq_en = 1'b0;
        m_limit  = 16'd1024;
    endtask

    // ---------------- core responder / payload monitor ----------------
    int          dly [NC];       // ack in strobe cycle dly+1, NEVER = no ack
    logic [31:0] rd [NC];
    int          age [NC];
    int          stb_cyc [NC];
    int          stable_err;
    logic        x_we;
    logic [3:0]  x_sel;
    logic [31:0] x_adr, x_dat;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NC; k++) begin
                core_din[32*k +: 32] = rd[k];
                if (core_stb[k]) begin
                    age[k]++;
                    stb_cyc[k]++;
                    core_ack[k] = (dly[k] != NEVER) && (age[k] == dly[k] + 1);
                end else begin
                    age[k]      = 0;
                    core_ack[k] = 1'b0;
                end
            end
            if (|core_stb && (core_we !== x_we || core_sel !== x_sel ||
                              core_adr !== x_adr[AW-1:0] || core_dout !== x_dat))
                stable_err++;
        end
    end

    function automatic logic [31:0] mk_adr(input logic [7:0] hi, input logic [3:0] i, input logic [19:0] off);
        return {hi, i, off};
    endfunction

    // ---------------- driver: one Wishbone transfer, predicted and checked ----------------
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
        logic        exp_ack, got;
        logic [31:0] exp_dat, got_dat;
        int          exp_lat, lat, L, t;
        int          exp_stb [NC];
        logic [3:0]  i;
        logic [NC-1:0] late;

        // prediction from the decode / timeout rules
        for (int k = 0; k < NC; k++) exp_stb[k] = 0;
        exp_ack = 1'b1;
        exp_dat = 32'd0;
        exp_lat = 2;
        i = a[23:20];
        L = int'(m_limit);
        if (a[31:24] != BASE_HI) begin
            exp_ack = 1'b0;
        end else if (int'(i) < NC) begin
            if (!m_mask[i]) begin
                exp_dat = ERR_DATA;
            end else if (dly[i] != NEVER && (L == 0 || dly[i] + 1 <= L)) begin
                exp_stb[i] = dly[i] + 1;
                exp_dat    = rd[i];
                exp_lat    = dly[i] + 3;
            end else begin
                exp_stb[i] = L;
                exp_dat    = TMO_DATA;
                exp_lat    = L + 2;
                m_flags[i] = 1'b1;
            end
        end else if (i == 4'hE) begin
            if (w && m_mask != '0) begin
                t = 0;
                late = '0;
                for (int k = 0; k < NC; k++) begin
                    if (m_mask[k]) begin
                        if (dly[k] == NEVER || (L != 0 && dly[k] + 1 > L)) late[k] = 1'b1;
                        else if (dly[k] + 1 > t) t = dly[k] + 1;
                    end
                end
                if (late == '0) begin
                    exp_lat = t + 2;
                end else begin
                    exp_lat = L + 2;
                    exp_dat = TMO_DATA;
                    m_flags = m_flags | late;
                end
                for (int k = 0; k < NC; k++)
                    if (m_mask[k]) exp_stb[k] = late[k] ? L : dly[k] + 1;
            end
        end else if (i == 4'hF) begin
            case (a[19:0])
                20'h0: exp_dat = 32'(m_flags);
                20'h4: exp_dat = (32'(m_mask) << 8) | 32'(m_irq_en);
                20'h8: exp_dat = 32'(m_limit);
                default: exp_dat = 32'd0;
            endcase
            if (w) begin
                case (a[19:0])
                    20'h0: m_flags = m_flags & ~d[NC-1:0];
                    20'h4: begin m_irq_en = d[0]; m_mask = d[8 +: NC]; end
                    20'h8: m_limit = d[15:0];
                    default: ;
                endcase
            end
        end else begin
            exp_dat = ERR_DATA;
        end
        if (exp_ack) exp_q.push_back(exp_dat);

        // drive
        for (int k = 0; k < NC; k++) stb_cyc[k] = 0;
        stable_err = 0;
        @(posedge clk);
        #1;
        x_sel = 4'($urandom_range(0, 15));
        x_we  = w;
        x_adr = a;
        x_dat = d;
        cyc = 1'b1; stb = 1'b1; we = w; sel = x_sel; adr = a; wdat = d;
        got = 1'b0;
        got_dat = '0;
        lat = 0;
        while (!got && lat < exp_lat + 4) begin
            @(negedge clk);
            lat++;
            if (ack) begin
                got = 1'b1;
                got_dat = rdat_o;
            end
        end
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;

        // compare
        check({tag, "_ack"}, 32'(got), 32'(exp_ack));
        if (got && exp_q.size() != 0) begin
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_dat"}, got_dat, exp_q.pop_front());
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        for (int k = 0; k < NC; k++)
            check($sformatf("%s_stb%0d", tag, k), stb_cyc[k], exp_stb[k]);
        check({tag, "_stable"}, stable_err, 0);
        check({tag, "_idle_stb"}, 32'(core_stb), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'(m_irq_en & (|m_flags)));
    endtask

    // ---------------- main sequence ----------------
    logic       seen;
    int         kind;
    logic [3:0] ridx;

    initial begin
        for (int k = 0; k < NC; k++) begin
            dly[k] = 0;
            rd[k]  = 32'd0;
            age[k] = 0;
            stb_cyc[k] = 0;
        end
        stable_err = 0;
        x_we = 1'b0; x_sel = '0; x_adr = '0; x_dat = '0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat_o, 32'd0);
        check("rst_stb", 32'(core_stb), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_adr", 32'(core_adr), 32'd0);
        rst_n = 1'b1;
        xfer(1'b0, mk_adr(BASE_HI, 4'hF, 20'h4), 32'd0, "rst_ctrl");
        xfer(1'b0, mk_adr(BASE_HI, 4'hF, 20'h8), 32'd0, "rst_limit");
        xfer(1'b0, mk_adr(BASE_HI, 4'hF, 20'h0), 32'd0, "rst_flags");

        // read core 2, ack 3 cycles after strobe
        dly[2] = 3;
        rd[2]  = 32'h1234_5678;
        xfer(1'b0, mk_adr(BASE_HI, 4'd2, 20'h10), 32'd0, "rd_core2");

        // broadcast with mask 1011, cores ack at cycles 1/4/2
        xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h4), 32'h0000_0B00, "set_mask_b");
        dly[0] = 1; dly[1] = 4; dly[2] = 0; dly[3] = 2;
        xfer(1'b1, mk_adr(BASE_HI, 4'hE, 20'h20), 32'hCAFE_0001, "bcast_b");

        // LIMIT=8, core 1 silent, irq enabled
        xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h4), 32'h0000_0F01, "set_irq");
        xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h8), 32'd8, "set_lim8");
        dly[1] = NEVER;
        xfer(1'b0, mk_adr(BASE_HI, 4'd1, 20'h0), 32'd0, "tmo_core1");
        xfer(1'b0, mk_adr(BASE_HI, 4'hF, 20'h0), 32'd0, "flags_after_tmo");

        // ack in the very cycle the timeout fires
        dly[3] = 7;
        xfer(1'b0, mk_adr(BASE_HI, 4'd3, 20'h4), 32'd0, "ack_vs_tmo");

        // W1C the flag, irq drops
        xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h0), 32'h0000_0002, "w1c");
        xfer(1'b0, mk_adr(BASE_HI, 4'hF, 20'h0), 32'd0, "flags_after_w1c");

        // disabled core, error index, foreign base
        xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h4), 32'h0000_0D01, "dis_core1");
        xfer(1'b0, mk_adr(BASE_HI, 4'd1, 20'h0), 32'd0, "rd_disabled");
        xfer(1'b0, mk_adr(BASE_HI, 4'h9, 20'h0), 32'd0, "rd_idx9");
        xfer(1'b0, mk_adr(8'h31, 4'd0, 20'h0), 32'd0, "rd_foreign");
        xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h4), 32'h0000_0F00, "mask_all");

        // master abort mid-forward: strobe drops, no ack, no flag
        xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h8), 32'd20, "set_lim20");
        dly[1] = NEVER;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = mk_adr(BASE_HI, 4'd1, 20'h0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        check("abort_fwd_stb", 32'(core_stb), 32'h2);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        if (ack) seen = 1'b1;
        @(posedge clk);
        #1;
        check("abort_stb", 32'(core_stb), 32'd0);
        check("abort_noack", 32'(seen), 32'd0);
        xfer(1'b0, mk_adr(BASE_HI, 4'hF, 20'h0), 32'd0, "abort_flags");

        // reset asserted mid-forward
        dly[2] = NEVER;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = mk_adr(BASE_HI, 4'd2, 20'h0);
        repeat (3) @(posedge clk);
        #3;
        check("rstmid_pre_stb", 32'(core_stb), 32'h4);
        rst_n = 1'b0;
        #1;
        check("rstmid_stb", 32'(core_stb), 32'd0);
        check("rstmid_ack", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        xfer(1'b0, mk_adr(BASE_HI, 4'hF, 20'h4), 32'd0, "rstmid_ctrl");

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < NC; k++) begin
                rd[k]  = $urandom;
                dly[k] = (m_limit != 0 && m_limit <= 16'd32 && $urandom_range(0, 5) == 0)
                         ? NEVER : int'($urandom_range(0, 10));
            end
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2: begin
                    ridx = 4'($urandom_range(0, NC - 1));
                    xfer(1'($urandom_range(0, 1)), mk_adr(BASE_HI, ridx, 20'($urandom)), $urandom, "r_core");
                end
                3: xfer(1'($urandom_range(0, 1)), mk_adr(BASE_HI, 4'hE, 20'($urandom)), $urandom, "r_bcast");
                4: xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h4),
                        {20'd0, 4'($urandom_range(0, 15)), 7'd0, 1'($urandom_range(0, 1))}, "r_ctrl");
                5: xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h8), 32'($urandom_range(0, 14)), "r_limit");
                6: xfer(1'b0, mk_adr(BASE_HI, 4'hF, 20'(4 * $urandom_range(0, 3))), 32'd0, "r_regrd");
                7: xfer(1'b1, mk_adr(BASE_HI, 4'hF, 20'h0), 32'($urandom_range(0, 15)), "r_w1c");
                8: xfer(1'($urandom_range(0, 1)), mk_adr(BASE_HI, 4'($urandom_range(NC, 13)), 20'd0), $urandom, "r_err");
                default: xfer(1'b0, mk_adr(BASE_HI ^ 8'($urandom_range(1, 255)), 4'd0, 20'd0), 32'd0, "r_foreign");
            endcase
        end
        xfer(1'b0, mk_adr(BASE_HI, 4'hF, 20'h0), 32'd0, "final_flags");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global bound on the run
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
